// File: rtl/snes_poll_scheduler_if.sv
// Signal bundle between the SNES poll scheduler, the controller connector
// pins and the memory-mapped I/O decode. The scheduler uses the master view;
// the surrounding logic (or a bench) uses the slave view.
interface snes_poll_scheduler_if;
    logic        poll_en;
    logic        poll_now;
    logic        serial_data0;
    logic        serial_data1;
    logic        clr_pressed;
    logic        clr_pad;
    logic [11:0] clr_mask;
    logic        snes_clk;
    logic        snes_latch;
    logic [11:0] buttons0;
    logic [11:0] buttons1;
    logic [11:0] pressed0;
    logic [11:0] pressed1;
    logic        frame_done;
    logic        busy;

    modport master (
        input  poll_en, poll_now, serial_data0, serial_data1,
        input  clr_pressed, clr_pad, clr_mask,
        output snes_clk, snes_latch, buttons0, buttons1,
        output pressed0, pressed1, frame_done, busy
    );

    modport slave (
        output poll_en, poll_now, serial_data0, serial_data1,
        output clr_pressed, clr_pad, clr_mask,
        input  snes_clk, snes_latch, buttons0, buttons1,
        input  pressed0, pressed1, frame_done, busy
    );
endinterface

// File: rtl/snes_poll_scheduler.sv
// SNES dual-pad poll scheduler: drives one shared latch/clock pair, shifts in
// 16 bits from both pads in parallel, commits 12 active-high button bits per
// pad and keeps sticky "newly pressed" flags that the CPU clears by mask.
// Optional build macro SNES_DEBOUNCE_EN: a button bit only changes when two
// consecutive scans agree on it.
module snes_poll_scheduler #(
    parameter int POLL_TICKS  = 20000,
    parameter int HALF_TICKS  = 7,
    parameter int LATCH_TICKS = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    snes_poll_scheduler_if.master  bus
);
    localparam int CNT_W    = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam int TICK_MAX = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(POLL_TICKS - 1);
    localparam logic [TICK_W-1:0] LATCH_LAST = TICK_W'(LATCH_TICKS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST  = TICK_W'(HALF_TICKS - 1);

    typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              first_q;
    logic              start;
    logic              snes_clk_q, snes_clk_d;
    logic              snes_latch_q, snes_latch_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic [11:0]       shift0_q, shift1_q;
    logic [11:0]       buttons0_q, buttons0_d, buttons1_q, buttons1_d;
    logic [11:0]       pressed0_q, pressed0_d, pressed1_q, pressed1_d;
    logic [11:0]       filt0, filt1, set0, set1, clr0, clr1;
`ifdef SNES_DEBOUNCE_EN
    logic [11:0]       prev0_q, prev1_q;

    // Take the new sample where it matches the previous scan, else hold.
    function automatic logic [11:0] debounce(input logic [11:0] smp,
                                             input logic [11:0] prev,
                                             input logic [11:0] cur);
        return ((smp ~^ prev) & smp) | ((smp ^ prev) & cur);
    endfunction
`endif

    // A freshly set flag always survives a clear issued in the same cycle.
    function automatic logic [11:0] pressed_next(input logic [11:0] cur,
                                                 input logic [11:0] set,
                                                 input logic [11:0] clr);
        return (cur & ~(clr & ~set)) | set;
    endfunction

    // The first idle cycle after reset counts as a due periodic scan.
    assign start = (state_q == IDLE) &&
                   (bus.poll_now || (bus.poll_en && (first_q || period_q == CNT_LAST)));

    // State register plus the registered strobes derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            period_q     <= '0;
            first_q      <= 1'b1;
            snes_clk_q   <= 1'b1;
            snes_latch_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            period_q     <= period_d;
            first_q      <= 1'b0;
            snes_clk_q   <= snes_clk_d;
            snes_latch_q <= snes_latch_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: phase timing, bit counter and saturating period counter.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q + TICK_W'(1);
        bit_d    = bit_q;
        period_d = (period_q == CNT_LAST) ? period_q : period_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (start) begin
                    state_d  = LATCH;
                    period_d = '0;
                    bit_d    = '0;
                end
            end
            LATCH: begin
                if (tick_q == LATCH_LAST) begin
                    state_d = CLK_HI;
                    tick_d  = '0;
                end
            end
            CLK_HI: begin
                if (tick_q == HALF_LAST) begin
                    state_d = CLK_LO;
                    tick_d  = '0;
                end
            end
            CLK_LO: begin
                if (tick_q == HALF_LAST) begin
                    tick_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLK_HI;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                tick_d  = '0;
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Output decode from the next state so the pins come straight from flops.
    always_comb begin
        snes_clk_d   = (state_d != CLK_LO);
        snes_latch_d = (state_d == LATCH);
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // Shift capture: the last CLK_HI cycle of each bit; bits 12..15 are dropped.
    always_ff @(posedge clk) begin
        if (state_q == CLK_HI && tick_q == HALF_LAST && bit_q < 4'd12) begin
            shift0_q[bit_q] <= ~bus.serial_data0;
            shift1_q[bit_q] <= ~bus.serial_data1;
        end
    end

    // Commit and pressed-flag update; clears apply in any cycle.
    always_comb begin
        filt0 = shift0_q;
        filt1 = shift1_q;
`ifdef SNES_DEBOUNCE_EN
        filt0 = debounce(shift0_q, prev0_q, buttons0_q);
        filt1 = debounce(shift1_q, prev1_q, buttons1_q);
`endif
        buttons0_d = buttons0_q;
        buttons1_d = buttons1_q;
        set0       = '0;
        set1       = '0;
        if (state_q == DONE) begin
            buttons0_d = filt0;
            buttons1_d = filt1;
            set0       = filt0 & ~buttons0_q;
            set1       = filt1 & ~buttons1_q;
        end
        clr0       = (bus.clr_pressed && !bus.clr_pad) ? bus.clr_mask : '0;
        clr1       = (bus.clr_pressed &&  bus.clr_pad) ? bus.clr_mask : '0;
        pressed0_d = pressed_next(pressed0_q, set0, clr0);
        pressed1_d = pressed_next(pressed1_q, set1, clr1);
    end

    // Button and pressed-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons0_q <= '0;
            buttons1_q <= '0;
            pressed0_q <= '0;
            pressed1_q <= '0;
        end else begin
            buttons0_q <= buttons0_d;
            buttons1_q <= buttons1_d;
            pressed0_q <= pressed0_d;
            pressed1_q <= pressed1_d;
        end
    end

`ifdef SNES_DEBOUNCE_EN
    // Previous raw scan per pad, used as the agreement reference.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev0_q <= '0;
            prev1_q <= '0;
        end else if (state_q == DONE) begin
            prev0_q <= shift0_q;
            prev1_q <= shift1_q;
        end
    end
`endif

    assign bus.snes_clk   = snes_clk_q;
    assign bus.snes_latch = snes_latch_q;
    assign bus.buttons0   = buttons0_q;
    assign bus.buttons1   = buttons1_q;
    assign bus.pressed0   = pressed0_q;
    assign bus.pressed1   = pressed1_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
endmodule
